// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: headings, game states and button indices.
// Also used by snake_movement, so the direction codes must stay stable.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  // Button slots; the four direction slots match their dir_t codes.
  localparam int BTN_UP    = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;
  localparam int BTN_PAUSE = 4;
  localparam int NUM_BTNS  = 5;

  // Opposite headings differ only in the upper encoding bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    logic [1:0] diff;
    diff = a ^ b;
    return diff == 2'b10;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchronizer -> stability debouncer -> one-cycle press pulse.
// Latency from a clean raw rising edge to the pulse is DEBOUNCE_CYCLES+3 cycles.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any sample matching the accepted level restarts the stability count.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    prev_d  = stable_q;
    press_d = stable_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/direction_controller.sv
// Snake game control: debounced buttons, pending/committed heading, move tick
// generation and the IDLE/RUN/PAUSE/OVER game state machine.
module direction_controller
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TICK_CYCLES     = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_pause,
  input  logic       collision,
  output logic [1:0] direction,
  output logic       move_tick,
  output logic       running,
  output logic       paused,
  output logic       game_over
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press;
  logic                dir_any;
  logic                pause_press;
  dir_t                req_dir;

  state_t        state_q, state_d;
  dir_t          direction_q, direction_d;
  dir_t          pending_q, pending_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          running_q, running_d;
  logic          paused_q, paused_d;
  logic          over_q, over_d;

  assign btn_raw = {btn_pause, btn_left, btn_down, btn_right, btn_up};

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(btn_raw[gi]),
      .press  (press[gi])
    );
  end

  assign dir_any     = |press[BTN_LEFT:BTN_UP];
  assign pause_press = press[BTN_PAUSE];

  // Only the highest-priority press is considered; a rejected one never falls through.
  always_comb begin
    if (press[BTN_UP])         req_dir = DIR_UP;
    else if (press[BTN_RIGHT]) req_dir = DIR_RIGHT;
    else if (press[BTN_DOWN])  req_dir = DIR_DOWN;
    else                       req_dir = DIR_LEFT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      direction_q <= DIR_RIGHT;
      pending_q   <= DIR_RIGHT;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
      paused_q    <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      direction_q <= direction_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
      paused_q    <= paused_d;
      over_q      <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (dir_any) state_d = ST_RUN;
      ST_RUN:   if (collision) state_d = ST_OVER;
                else if (pause_press) state_d = ST_PAUSE;
      ST_PAUSE: if (collision) state_d = ST_OVER;
                else if (pause_press) state_d = ST_RUN;
      default:  state_d = ST_OVER;
    endcase
  end

  always_comb begin
    tick_d = 1'b0;
    cnt_d  = cnt_q;
    case (state_q)
      ST_IDLE: cnt_d = '0;
      ST_RUN: begin
        // The counter only advances while staying in RUN, so a pause freezes it exactly.
        if (state_d == ST_RUN) begin
          if (cnt_q == TICK_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: cnt_d = cnt_q;
    endcase

    direction_d = tick_d ? pending_q : direction_q;

    // Judge reversal against the heading that holds after this edge, so a press
    // landing on a tick cycle can never queue a reversal of the new heading.
    pending_d = pending_q;
    if (state_q != ST_OVER && dir_any && !is_reverse(req_dir, direction_d)) begin
      pending_d = req_dir;
    end

    running_d = (state_d == ST_RUN);
    paused_d  = (state_d == ST_PAUSE);
    over_d    = (state_d == ST_OVER);
  end

  assign direction = direction_q;
  assign move_tick = tick_q;
  assign running   = running_q;
  assign paused    = paused_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_direction_controller.sv
// Directed bench for direction_controller with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
// Cycle n means "just after the n-th rising edge following reset release".
module tb_direction_controller;

  localparam int unsigned DEB  = 4;
  localparam int unsigned TICK = 8;

  logic       clk;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right, btn_pause;
  logic       collision;
  logic [1:0] direction;
  logic       move_tick, running, paused, game_over;

  int cyc;
  int checks;
  int passes;

  typedef struct {
    logic [3:0] m1;    // {left, down, right, up} pressed together from IDLE
    logic [1:0] exp1;  // heading after the first tick
    logic [3:0] m2;    // second simultaneous press while running
    logic [1:0] exp2;  // heading after the tick following that press
  } vec_t;

  vec_t vecs [8];

  direction_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_CYCLES    (TICK)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_pause(btn_pause),
    .collision(collision),
    .direction(direction),
    .move_tick(move_tick),
    .running  (running),
    .paused   (paused),
    .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic set_btns(input logic [3:0] m);
    btn_up    = m[0];
    btn_right = m[1];
    btn_down  = m[2];
    btn_left  = m[3];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_btns(4'b0000);
    btn_pause = 1'b0;
    collision = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int bad;
    checks = 0;
    passes = 0;
    cyc    = 0;
    vecs[0] = '{m1: 4'b0001, exp1: 2'b00, m2: 4'b0100, exp2: 2'b00};
    vecs[1] = '{m1: 4'b0001, exp1: 2'b00, m2: 4'b1100, exp2: 2'b00};
    vecs[2] = '{m1: 4'b0010, exp1: 2'b01, m2: 4'b1000, exp2: 2'b01};
    vecs[3] = '{m1: 4'b0100, exp1: 2'b10, m2: 4'b1010, exp2: 2'b01};
    vecs[4] = '{m1: 4'b1000, exp1: 2'b01, m2: 4'b0011, exp2: 2'b00};
    vecs[5] = '{m1: 4'b1100, exp1: 2'b10, m2: 4'b0001, exp2: 2'b10};
    vecs[6] = '{m1: 4'b1111, exp1: 2'b00, m2: 4'b1010, exp2: 2'b01};
    vecs[7] = '{m1: 4'b1001, exp1: 2'b00, m2: 4'b1000, exp2: 2'b11};

    reset = 1'b1;
    set_btns(4'b0000);
    btn_pause = 1'b0;
    collision = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_direction", direction, 1);
    chk("rst_move_tick", move_tick, 0);
    chk("rst_running", running, 0);
    chk("rst_paused", paused, 0);
    chk("rst_game_over", game_over, 0);

    // Clean UP press from reset: pulse at 7, RUN at 8, ticks at 16/24/32.
    do_reset();
    btn_up = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      step();
      if (c == 10) btn_up = 1'b0;
      chk("start_move_tick", move_tick, (c == 16 || c == 24 || c == 32) ? 1 : 0);
      chk("start_running", running, (c >= 8) ? 1 : 0);
      chk("start_direction", direction, (c >= 16) ? 0 : 1);
    end
    $display("start sequence: direction=%0d running=%0d at cycle %0d", direction, running, cyc);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      set_btns(vecs[v].m1);
      wait_to(8);
      chk("vec_running", running, 1);
      wait_to(10);
      set_btns(4'b0000);
      wait_to(16);
      chk("vec_tick16", move_tick, 1);
      wait_to(17);
      chk("vec_dir1", direction, vecs[v].exp1);
      wait_to(18);
      set_btns(vecs[v].m2);
      wait_to(24);
      set_btns(4'b0000);
      wait_to(32);
      chk("vec_tick32", move_tick, 1);
      wait_to(34);
      chk("vec_dir2", direction, vecs[v].exp2);
      $display("vector %0d: m1=%b m2=%b dir1/dir2 expected %0d/%0d", v, vecs[v].m1,
               vecs[v].m2, vecs[v].exp1, vecs[v].exp2);
    end

    // Reversal rejected, then DOWN before a tick and LEFT just after it.
    do_reset();
    btn_right = 1'b1;
    wait_to(10); btn_right = 1'b0;
    wait_to(12); btn_left = 1'b1;
    wait_to(20); btn_left = 1'b0;
    wait_to(25); chk("turn_reject_a", direction, 1);
    wait_to(33); chk("turn_reject_b", direction, 1);
    wait_to(35); btn_down = 1'b1;
    wait_to(41); btn_down = 1'b0;
    chk("turn_before_down", direction, 1);
    wait_to(43); btn_left = 1'b1;
    wait_to(47); chk("turn_pre_tick48", direction, 1);
    wait_to(48); chk("turn_down", direction, 2);
    wait_to(49); btn_left = 1'b0;
    wait_to(55); chk("turn_pre_tick56", direction, 2);
    wait_to(56); chk("turn_left", direction, 3);
    $display("turn sequence: final direction=%0d at cycle %0d", direction, cyc);

    // Bouncing RIGHT never debounces; collision in IDLE is ignored.
    do_reset();
    collision = 1'b1;
    for (int i = 0; i < 20; i++) begin
      btn_right = ((i / 2) % 2 == 0);
      step();
    end
    btn_right = 1'b0;
    collision = 1'b0;
    wait_to(35);
    chk("bounce_running", running, 0);
    chk("bounce_paused", paused, 0);
    chk("bounce_game_over", game_over, 0);
    chk("bounce_direction", direction, 1);
    $display("bounce sequence: running=%0d game_over=%0d", running, game_over);

    // Pause at counter 5, DOWN queued while paused, resume ticks 3 cycles later.
    do_reset();
    btn_up = 1'b1;
    wait_to(6);  btn_pause = 1'b1;
    wait_to(10); btn_up = 1'b0;
    wait_to(12); btn_pause = 1'b0;
    wait_to(14);
    chk("pause_paused", paused, 1);
    chk("pause_running", running, 0);
    bad = 0;
    while (cyc < 113) begin
      step();
      if (move_tick) bad++;
      if (cyc == 40) btn_down = 1'b1;
      if (cyc == 50) btn_down = 1'b0;
      if (cyc == 110) btn_pause = 1'b1;
    end
    chk("pause_no_tick", bad, 0);
    chk("pause_direction", direction, 1);
    wait_to(116); btn_pause = 1'b0;
    wait_to(117); chk("resume_still_paused", paused, 1);
    wait_to(118);
    chk("resume_running", running, 1);
    chk("resume_tick118", move_tick, 0);
    wait_to(119); chk("resume_tick119", move_tick, 0);
    wait_to(120); chk("resume_tick120", move_tick, 0);
    wait_to(121);
    chk("resume_tick121", move_tick, 1);
    chk("resume_direction", direction, 2);
    $display("pause sequence: resumed tick=%0d direction=%0d at cycle %0d", move_tick, direction, cyc);

    // Collision on the wrap cycle wins over the tick; OVER ignores every press.
    do_reset();
    btn_up = 1'b1;
    collision = 1'b1;
    wait_to(4);  collision = 1'b0;
    wait_to(8);
    chk("over_running_pre", running, 1);
    chk("over_flag_pre", game_over, 0);
    wait_to(10); btn_up = 1'b0;
    wait_to(15); collision = 1'b1;
    step();
    chk("over_no_tick", move_tick, 0);
    chk("over_flag", game_over, 1);
    chk("over_running", running, 0);
    chk("over_direction", direction, 1);
    collision = 1'b0;
    wait_to(17);
    set_btns(4'b1111);
    btn_pause = 1'b1;
    bad = 0;
    while (cyc < 40) begin
      step();
      if (move_tick) bad++;
      if (cyc == 27) begin
        set_btns(4'b0000);
        btn_pause = 1'b0;
      end
    end
    chk("over_no_tick_later", bad, 0);
    chk("over_flag_held", game_over, 1);
    chk("over_running_held", running, 0);
    chk("over_paused_held", paused, 0);
    chk("over_direction_held", direction, 1);
    $display("over sequence: game_over=%0d direction=%0d", game_over, direction);

    // Reset mid-RUN on a tick cycle, with UP held through reset release.
    do_reset();
    btn_up = 1'b1;
    wait_to(24);
    chk("midrst_tick_before", move_tick, 1);
    chk("midrst_dir_before", direction, 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_direction", direction, 1);
    chk("midrst_move_tick", move_tick, 0);
    chk("midrst_running", running, 0);
    repeat (2) step();
    reset = 1'b1;
    cyc = 0;
    wait_to(7); chk("held_running7", running, 0);
    wait_to(8); chk("held_running8", running, 1);
    btn_up = 1'b0;
    $display("reset sequence: running=%0d at cycle %0d", running, cyc);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/direction_controller.md
DIRECTION_CONTROLLER -- requirements
Module: direction_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable cycles needed to accept a button level (10 ms at 100 MHz).
REQ-002 Parameter TICK_CYCLES, default 10_000_000, cycles between snake moves (10 moves/s at 100 MHz).
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 btn_up, btn_down, btn_left, btn_right  input  1 each  raw, asynchronous, active-high direction buttons.
REQ-006 btn_pause  input  1  raw, asynchronous, active-high pause/resume button.
REQ-007 collision  input  1  level from the renderer; high = snake hit wall or self.
REQ-008 direction  output  2  committed heading to snake_movement: UP=00, RIGHT=01, DOWN=10, LEFT=11.
REQ-009 move_tick  output  1  one-cycle pulse; snake_movement advances one cell per pulse.
REQ-010 running, paused, game_over  output  1 each  state flags, mutually exclusive.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-012 Each debouncer SHALL emit a one-cycle press pulse on an accepted 0->1 transition only; releases and held buttons produce no further pulses.
REQ-013 Raw-edge-to-press-pulse latency SHALL be exactly DEBOUNCE_CYCLES+3 cycles for a clean edge.
REQ-014 Bounce shorter than DEBOUNCE_CYCLES SHALL restart the stability count and produce no pulse.
REQ-015 A pending-direction register SHALL capture a direction press unless it is the reverse of the committed direction (pressed XOR direction == 10).
REQ-016 Simultaneous direction presses SHALL resolve by priority UP > RIGHT > DOWN > LEFT; rejected reversals never fall through to a lower-priority press.
REQ-017 Later valid presses before a tick SHALL overwrite pending; direction SHALL load pending only in the cycle move_tick is high (so two quick turns can never reverse the snake).
REQ-018 FSM states: IDLE, RUN, PAUSE, OVER; IDLE->RUN on any accepted direction press, PAUSE press ignored in IDLE.
REQ-019 RUN: tick counter counts 0..TICK_CYCLES-1, wraps to 0, and move_tick is asserted in the wrap cycle; first tick occurs TICK_CYCLES cycles after entering RUN (counter cleared on entry).
REQ-020 RUN->PAUSE on pause press; PAUSE->RUN on pause press; counter holds its value in PAUSE, move_tick low, direction presses still update pending.
REQ-021 collision high in RUN or PAUSE SHALL move to OVER next cycle; collision in IDLE is ignored.
REQ-022 collision and counter wrap in the same cycle: collision wins, move_tick SHALL NOT assert.
REQ-023 Pause press and collision in the same cycle: collision wins (OVER).
REQ-024 OVER is terminal until reset; move_tick low, direction frozen, all presses ignored.
REQ-025 running=RUN, paused=PAUSE, game_over=OVER, all registered; none asserted in IDLE.

Reset
REQ-026 On reset low, asynchronously: state IDLE, direction=RIGHT, pending=RIGHT, counter 0, move_tick 0, all flags 0, synchronizers and debouncers cleared to released (0).
REQ-027 Reset mid-RUN or mid-debounce SHALL discard partial counts; a button held through reset release SHALL produce a press pulse after DEBOUNCE_CYCLES+3 cycles.

Structure
REQ-028 Direction encodings and FSM state encodings SHALL live in shared package snake_pkg, also used by snake_movement.
REQ-029 One sub-module, btn_debounce (synchronizer + debouncer + press pulse, parameter DEBOUNCE_CYCLES), SHALL be instantiated five times.
REQ-030 Counters SHALL be sized by $clog2 of their parameter; no division or multiplication in logic.

Verification (DEBOUNCE_CYCLES=4, TICK_CYCLES=8)
REQ-031 Reset, hold btn_up clean -> press pulse at cycle 7, state RUN at 8, move_tick at cycles 16, 24, 32; direction UP from cycle 16.
REQ-032 RUN heading RIGHT, press LEFT -> rejected, direction stays 01; press DOWN then LEFT within one tick period -> direction 10 at next tick, 11 at the following tick.
REQ-033 btn_right toggling every 2 cycles for 20 cycles -> no press pulse, state unchanged.
REQ-034 Pause press at counter=5 -> move_tick absent for 100 cycles; resume -> next tick exactly 3 cycles after PAUSE->RUN.
REQ-035 collision asserted on the cycle the counter wraps -> no move_tick, game_over=1 next cycle, stays 1 under further presses until reset.
REQ-036 Assert reset low mid-RUN -> same cycle: direction=01, move_tick=0, running=0.
